// File: rtl/wave_filt_pipe.sv
// Horizontal wave/warp remapper: rewrites hcount from a piecewise parabola of vcount.
// Three register stages: parabola terms, product and sum, then wrap into the active width.
module wave_filt_pipe #(
    parameter int unsigned H_ACTIVE   = 240,
    parameter int unsigned V_ACTIVE   = 320,
    parameter int unsigned PIX_W      = 7,
    parameter int unsigned SHIFT      = 4,
    parameter int unsigned PHASE_STEP = 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [1:0]       mode_in,
    input  logic             frame_start_in,
    input  logic             data_valid_in,
    input  logic [PIX_W-1:0] data_in,
    input  logic [10:0]      hcount_in,
    input  logic [9:0]       vcount_in,
    output logic             data_valid_out,
    output logic [10:0]      hcount_out,
    output logic [9:0]       vcount_out,
    output logic [PIX_W-1:0] pixel_out,
    output logic [10:0]      phase_out
);
    localparam int TW = 13;
    localparam int PW = 2 * TW;
    localparam int SW = PW + 1;

    localparam logic signed [TW-1:0] V_FULL = TW'(V_ACTIVE);
    localparam logic signed [TW-1:0] V_HALF = TW'(V_ACTIVE / 2);
    localparam logic signed [SW-1:0] H_MOD  = SW'(H_ACTIVE);
    localparam logic signed [SW-1:0] H_LAST = SW'(H_ACTIVE - 1);

    typedef enum logic [1:0] {ModeBypass, ModeWarp, ModeAnim, ModeMirror} mode_e;

    // Frame-level state
    mode_e       mode_q;
    logic [10:0] phase_q, phase_d;
    logic [11:0] ph_sum;

    assign ph_sum  = {1'b0, phase_q} + 12'(PHASE_STEP);
    assign phase_d = (ph_sum >= 12'(H_ACTIVE)) ? 11'(ph_sum - 12'(H_ACTIVE)) : ph_sum[10:0];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mode_q  <= ModeBypass;
            phase_q <= '0;
        end else if (frame_start_in) begin
            mode_q  <= mode_e'(mode_in);
            phase_q <= phase_d;
        end
    end

    assign phase_out = phase_q;

    // Stage 1: parabola terms
    logic signed [TW-1:0] v_s, top_d, mid_d, bot_d;
    logic                 sel_d, ok_d;

    assign v_s   = {{(TW-10){1'b0}}, vcount_in};
    assign top_d = (v_s - V_FULL) >>> SHIFT;
    assign mid_d = (v_s - V_HALF) >>> SHIFT;
    assign bot_d = (-v_s) >>> SHIFT;
    assign sel_d = v_s > V_HALF;
    assign ok_d  = (32'(hcount_in) < H_ACTIVE) && (32'(vcount_in) < V_ACTIVE);

    logic                 s1_valid_q, s1_sel_q, s1_ok_q;
    logic [10:0]          s1_h_q, s1_phase_q;
    logic [9:0]           s1_v_q;
    logic [PIX_W-1:0]     s1_pix_q;
    mode_e                s1_mode_q;
    logic signed [TW-1:0] s1_top_q, s1_mid_q, s1_bot_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            s1_sel_q   <= 1'b0;
            s1_ok_q    <= 1'b0;
            s1_h_q     <= '0;
            s1_phase_q <= '0;
            s1_v_q     <= '0;
            s1_pix_q   <= '0;
            s1_mode_q  <= ModeBypass;
            s1_top_q   <= '0;
            s1_mid_q   <= '0;
            s1_bot_q   <= '0;
        end else begin
            s1_valid_q <= data_valid_in;
            s1_sel_q   <= sel_d;
            s1_ok_q    <= ok_d;
            s1_h_q     <= hcount_in;
            s1_phase_q <= phase_q;
            s1_v_q     <= vcount_in;
            s1_pix_q   <= data_in;
            s1_mode_q  <= mode_q;
            s1_top_q   <= top_d;
            s1_mid_q   <= mid_d;
            s1_bot_q   <= bot_d;
        end
    end

    // Stage 2: product and per-mode sum
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] h_ext, k_ext, ph_ext, s2_val_d;
    logic                 s2_wrap_d;

    assign prod   = s1_sel_q ? s1_mid_q * s1_top_q : s1_mid_q * s1_bot_q;
    assign k_ext  = {{(SW-PW){prod[PW-1]}}, prod};
    assign h_ext  = {{(SW-11){1'b0}}, s1_h_q};
    assign ph_ext = {{(SW-11){1'b0}}, s1_phase_q};

    always_comb begin
        s2_val_d  = h_ext;
        s2_wrap_d = 1'b0;
        if (s1_ok_q) begin
            unique case (s1_mode_q)
                ModeWarp: begin
                    s2_val_d  = h_ext + k_ext;
                    s2_wrap_d = 1'b1;
                end
                ModeAnim: begin
                    s2_val_d  = h_ext + k_ext + ph_ext;
                    s2_wrap_d = 1'b1;
                end
                ModeMirror: s2_val_d = H_LAST - h_ext;
                default: ;
            endcase
        end
    end

    logic                 s2_valid_q, s2_wrap_q;
    logic signed [SW-1:0] s2_val_q;
    logic [9:0]           s2_v_q;
    logic [PIX_W-1:0]     s2_pix_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_valid_q <= 1'b0;
            s2_wrap_q  <= 1'b0;
            s2_val_q   <= '0;
            s2_v_q     <= '0;
            s2_pix_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_wrap_q  <= s2_wrap_d;
            s2_val_q   <= s2_val_d;
            s2_v_q     <= s1_v_q;
            s2_pix_q   <= s1_pix_q;
        end
    end

    // Stage 3: non-negative remainder, valid across any number of H_ACTIVE multiples
    logic signed [SW-1:0] rem, h_fin;

    always_comb begin
        rem = s2_val_q % H_MOD;
        if (rem < 0) begin
            rem = rem + H_MOD;
        end
        h_fin = s2_wrap_q ? rem : s2_val_q;
    end

    logic             valid_q;
    logic [10:0]      hcount_q;
    logic [9:0]       vcount_q;
    logic [PIX_W-1:0] pixel_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q  <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            pixel_q  <= '0;
        end else begin
            valid_q  <= s2_valid_q;
            hcount_q <= s2_valid_q ? h_fin[10:0] : '0;
            vcount_q <= s2_valid_q ? s2_v_q : '0;
            pixel_q  <= s2_valid_q ? s2_pix_q : '0;
        end
    end

    assign data_valid_out = valid_q;
    assign hcount_out     = hcount_q;
    assign vcount_out     = vcount_q;
    assign pixel_out      = pixel_q;

endmodule
